// File: rtl/twiddle_mult_pipe.sv
// Pipelined complex twiddle multiplier for radix-2 FFT/IFFT stages: y = x*W(k) and -y.
// Four stages: ROM read/quadrant decode, sign/swap, four products, add/round/negate.
module twiddle_mult_pipe #(
  parameter int  LOG2_NFFT = 6,
  parameter int  DATA_W    = 16,
  parameter int  TW_W      = 17,
  parameter int  GROW      = 0,
  parameter int  USE_ROUND = 1,
  parameter int  TAG_W     = 8,
  localparam int OW        = DATA_W + 1 + GROW
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic                        i_inv,
  input  logic        [LOG2_NFFT-1:0] i_k,
  input  logic signed [DATA_W-1:0]    i_re,
  input  logic signed [DATA_W-1:0]    i_im,
  input  logic        [TAG_W-1:0]     i_tag,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic signed [OW-1:0]        o_re,
  output logic signed [OW-1:0]        o_im,
  output logic signed [OW-1:0]        o_nre,
  output logic signed [OW-1:0]        o_nim,
  output logic        [TAG_W-1:0]     o_tag
);

  localparam int  N    = 1 << LOG2_NFFT;
  localparam int  M    = N / 4;
  localparam int  IW   = LOG2_NFFT - 1;
  localparam int  SH   = TW_W - 2 - GROW;
  localparam int  PW_P = DATA_W + TW_W;
  localparam int  PW_S = PW_P + 1;
  localparam real PI   = 3.14159265358979323846;
  localparam logic signed [PW_S-1:0] RND =
    (USE_ROUND != 0) ? PW_S'(longint'(1) << (SH - 1)) : '0;

  function automatic logic signed [TW_W-1:0] cos_entry(input int r);
    real v;
    v = $cos(2.0 * PI * real'(r) / real'(N)) * real'(1 << (TW_W - 2));
    return TW_W'($rtoi(v + 0.5));
  endfunction

  // Quarter-wave cosine table, entries 0..N/4, folded to constants at elaboration.
  logic signed [TW_W-1:0] rom [0:M];
  for (genvar g = 0; g <= M; g++) begin : g_rom
    assign rom[g] = cos_entry(g);
  end

  logic [IW-1:0] r_idx, rm_idx;
  if (LOG2_NFFT > 2) begin : g_ridx
    assign r_idx = IW'(i_k[LOG2_NFFT-3:0]);
  end else begin : g_ridx0
    assign r_idx = '0;
  end
  assign rm_idx = IW'(M) - r_idx;

  logic ce;
  assign ce      = i_ready | ~o_valid;
  assign o_ready = ce;

  logic                     v1_q, v2_q, v3_q;
  logic                     inv1_q;
  logic [1:0]               quad1_q;
  logic signed [TW_W-1:0]   ca1_q, cb1_q;
  logic signed [DATA_W-1:0] xr1_q, xi1_q, xr2_q, xi2_q;
  logic [TAG_W-1:0]         tag1_q, tag2_q, tag3_q;
  logic signed [TW_W-1:0]   c2_d, s2_d, c2_q, s2_q;
  logic signed [PW_P-1:0]   p_rc_q, p_is_q, p_ic_q, p_rs_q;
  logic signed [PW_S-1:0]   sum_re, sum_im;
  logic signed [OW-1:0]     re_d, im_d;

  // NOTE: both outputs get a value before the case so no path leaves them unassigned (no latch).
  always_comb begin
    c2_d = ca1_q;
    s2_d = cb1_q;
    case (quad1_q)
      2'd1:    begin c2_d = -cb1_q; s2_d =  ca1_q; end
      2'd2:    begin c2_d = -ca1_q; s2_d = -cb1_q; end
      2'd3:    begin c2_d =  cb1_q; s2_d = -ca1_q; end
      default: ;
    endcase
    if (inv1_q) s2_d = -s2_d;
  end

  assign sum_re = PW_S'(p_rc_q) + PW_S'(p_is_q);
  assign sum_im = PW_S'(p_ic_q) - PW_S'(p_rs_q);
  assign re_d   = OW'((sum_re + RND) >>> SH);
  assign im_d   = OW'((sum_im + RND) >>> SH);

  // NOTE: datapath registers carry no reset; only the valid bits and outputs need a known value.
  always_ff @(posedge i_clk) begin
    if (ce) begin
      inv1_q  <= i_inv;
      quad1_q <= i_k[LOG2_NFFT-1:LOG2_NFFT-2];
      ca1_q   <= rom[r_idx];
      cb1_q   <= rom[rm_idx];
      xr1_q   <= i_re;
      xi1_q   <= i_im;
      tag1_q  <= i_tag;
      c2_q    <= c2_d;
      s2_q    <= s2_d;
      xr2_q   <= xr1_q;
      xi2_q   <= xi1_q;
      tag2_q  <= tag1_q;
      p_rc_q  <= PW_P'(xr2_q) * PW_P'(c2_q);
      p_is_q  <= PW_P'(xi2_q) * PW_P'(s2_q);
      p_ic_q  <= PW_P'(xi2_q) * PW_P'(c2_q);
      p_rs_q  <= PW_P'(xr2_q) * PW_P'(s2_q);
      tag3_q  <= tag2_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      o_valid <= 1'b0;
      o_re    <= '0;
      o_im    <= '0;
      o_nre   <= '0;
      o_nim   <= '0;
      o_tag   <= '0;
    end else if (ce) begin
      v1_q    <= i_valid;
      v2_q    <= v1_q;
      v3_q    <= v2_q;
      o_valid <= v3_q;
      o_re    <= re_d;
      o_im    <= im_d;
      o_nre   <= -re_d;
      o_nim   <= -im_d;
      o_tag   <= tag3_q;
    end
  end

endmodule
